// File: rtl/lifo_fifo_pkg.sv
// Shared constants and helpers for the run-time selectable LIFO/FIFO buffer.
package lifo_fifo_pkg;

  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  // Threshold compare on an occupancy value; callers zero-extend their
  // ADDR_W+1 bit count, so the compare is exact for any depth.
  function automatic logic th_hit(input int unsigned cnt, input int unsigned th,
                                  input logic at_least);
    return at_least ? (cnt >= th) : (cnt <= th);
  endfunction

endpackage

// File: rtl/buf_ram.sv
// DEPTH x WIDTH storage: one write port, one synchronous registered read port.
module buf_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // Array has no reset; a same-edge write to the read slot returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lifo_fifo_buf.sv
// Buffer with run-time LIFO/FIFO ordering, occupancy flags and sticky errors.
module lifo_fifo_buf
  import lifo_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned AF_TH  = 14,
  parameter int unsigned AE_TH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_i,
  output logic              mode_o,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [ADDR_W-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic              mode_d, mode_q;
  logic              ovf_d, ovf_q, udf_d, udf_q, vld_d, vld_q;
  logic              rd_acc, wr_acc;
  logic [ADDR_W-1:0] top, ram_waddr, ram_raddr;

  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign rd_acc = rd_en & ~empty;
  // A full buffer still takes a write when a read frees a slot the same edge.
  assign wr_acc = wr_en & (~full | rd_acc);

  assign top       = ADDR_W'(cnt_q - CNT_W'(1));
  assign ram_raddr = (mode_q == MODE_FIFO) ? rptr_q : top;
  assign ram_waddr = (mode_q == MODE_FIFO) ? wptr_q :
                     (rd_acc ? top : ADDR_W'(cnt_q));

  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mode_d = mode_q;
    if (rd_acc) cnt_d = cnt_d - CNT_W'(1);
    if (wr_acc) cnt_d = cnt_d + CNT_W'(1);
    if (mode_q == MODE_FIFO) begin
      if (rd_acc) rptr_d = rptr_q + ADDR_W'(1);
      if (wr_acc) wptr_d = wptr_q + ADDR_W'(1);
    end
    // Ordering may only change while the buffer is and stays empty.
    if (empty && !wr_acc) begin
      mode_d = mode_i;
      wptr_d = '0;
      rptr_d = '0;
    end
    ovf_d = (ovf_q & ~clr_err) | (wr_en & ~wr_acc);
    udf_d = (udf_q & ~clr_err) | (rd_en & ~rd_acc);
    vld_d = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      mode_q <= MODE_LIFO;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      vld_q  <= vld_d;
    end
  end

  buf_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (ram_waddr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  assign mode_o       = mode_q;
  assign count        = cnt_q;
  assign rd_valid     = vld_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign almost_full  = th_hit(32'(cnt_q), AF_TH, 1'b1);
  assign almost_empty = th_hit(32'(cnt_q), AE_TH, 1'b0);

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_lifo_fifo_buf;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF_TH = 14;
  localparam int unsigned AE_TH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0, mode_i = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic mode_o, rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [WIDTH-1:0] rd_data;
  logic [ADDR_W:0] count;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer contents as a plain queue, oldest first.
  logic [WIDTH-1:0] mq[$];
  logic m_mode = 1'b0, m_vld = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  logic [WIDTH-1:0] m_rdd = '0;

  always #5 clk = ~clk;

  lifo_fifo_buf #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .mode_o(mode_o), .wr_en(wr_en),
    .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    int n = mq.size();
    logic ra, wa;
    ra = rd_en && (n != 0);
    wa = wr_en && ((n != DEPTH) || ra);
    if (rst) begin
      mq.delete();
      m_mode = 1'b0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_rdd = '0;
    end else begin
      m_vld = ra;
      if (ra) m_rdd = m_mode ? mq.pop_front() : mq.pop_back();
      if (wa) mq.push_back(wr_data);
      m_ovf = (m_ovf && !clr_err) || (wr_en && !wa);
      m_udf = (m_udf && !clr_err) || (rd_en && !ra);
      if (n == 0 && !wa) m_mode = mode_i;
    end
  endtask

  task automatic check_all();
    int n = mq.size();
    check_eq("count", 32'(count), 32'(n));
    check_eq("full", 32'(full), 32'(n == DEPTH));
    check_eq("empty", 32'(empty), 32'(n == 0));
    check_eq("almost_full", 32'(almost_full), 32'(n >= AF_TH));
    check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
    check_eq("mode_o", 32'(mode_o), 32'(m_mode));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("underflow", 32'(underflow), 32'(m_udf));
    check_eq("rd_valid", 32'(rd_valid), 32'(m_vld));
    check_eq("rd_data", 32'(rd_data), 32'(m_rdd));
  endtask

  task automatic step(input logic r, input logic we, input logic [WIDTH-1:0] wd,
                      input logic re, input logic ce);
    rst = r; wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d); step(1'b0, 1'b1, d, 1'b0, 1'b0); endtask
  task automatic pop();  step(1'b0, 1'b0, '0, 1'b1, 1'b0); endtask
  task automatic idle(); step(1'b0, 1'b0, '0, 1'b0, 1'b0); endtask

  initial begin
    int p;
    // Reset state.
    mode_i = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);

    // LIFO ordering.
    push(8'h11); push(8'h22); push(8'h33);
    pop();  check_eq("lifo_pop0", 32'(rd_data), 32'h33);
    pop();  check_eq("lifo_pop1", 32'(rd_data), 32'h22);
    pop();  check_eq("lifo_pop2", 32'(rd_data), 32'h11);
    check_eq("lifo_drained", 32'(empty), 32'd1);

    // FIFO ordering, overflow at full, pointer wrap.
    mode_i = 1'b1; idle();
    check_eq("fifo_mode", 32'(mode_o), 32'd1);
    for (int i = 1; i <= 16; i++) push(WIDTH'(i));
    check_eq("fifo_full", 32'(full), 32'd1);
    push(8'h99);
    check_eq("fifo_ovf", 32'(overflow), 32'd1);
    check_eq("fifo_ovf_cnt", 32'(count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      pop(); check_eq("fifo_order", 32'(rd_data), 32'(i));
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // LIFO simultaneous read/write.
    mode_i = 1'b0; idle();
    push(8'hA0); push(8'hB0);
    step(1'b0, 1'b1, 8'hC0, 1'b1, 1'b0);
    check_eq("lifo_rw_data", 32'(rd_data), 32'hB0);
    check_eq("lifo_rw_cnt", 32'(count), 32'd2);
    pop();  check_eq("lifo_rw_next", 32'(rd_data), 32'hC0);
    pop();

    // Read+write on empty: write wins, read flagged.
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    check_eq("empty_rw_udf", 32'(underflow), 32'd1);
    check_eq("empty_rw_vld", 32'(rd_valid), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("clr_udf", 32'(underflow), 32'd0);
    pop();  check_eq("empty_rw_pop", 32'(rd_data), 32'h5A);

    // Mode change only once empty and idle.
    push(8'h01); push(8'h02); push(8'h03);
    mode_i = 1'b1; idle();
    check_eq("mode_held", 32'(mode_o), 32'd0);
    pop(); pop(); pop();
    check_eq("mode_held_drain", 32'(mode_o), 32'd0);
    idle();
    check_eq("mode_loaded", 32'(mode_o), 32'd1);

    // Reset mid-burst with a read pending, then refill across thresholds.
    for (int i = 0; i < 15; i++) push(WIDTH'($urandom));
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check_eq("rst_mid_cnt", 32'(count), 32'd0);
    check_eq("rst_mid_vld", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 16; i++) push(WIDTH'($urandom));

    // Random traffic in segments of varying write bias.
    for (int seg = 0; seg < 20; seg++) begin
      p = (seg % 3 == 0) ? 80 : ((seg % 3 == 1) ? 20 : 50);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 19) == 0) mode_i = 1'($urandom);
        step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 99) < p),
             WIDTH'($urandom), 1'($urandom_range(0, 99) < 100 - p),
             1'($urandom_range(0, 19) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo_fifo_buf.md
Name: lifo_fifo_buf

Overview:
Parametrised next-generation buffer for the buffering library. Selectable at run time between LIFO (stack) and FIFO (queue) ordering.
- Adds over the previous stack: registered read with valid strobe, occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer that each use single-cycle enable strobes.

Parameters:
WIDTH, 8, data word width in bits (>=1)
ADDR_W, 4, log2 of depth; DEPTH = 2**ADDR_W entries (>=1)
AF_TH, 14, almost_full asserted when count >= AF_TH (0..DEPTH)
AE_TH, 2, almost_empty asserted when count <= AE_TH (0..DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
mode_i  input  1  requested ordering: 0 = LIFO, 1 = FIFO
mode_o  output  1  ordering currently in effect
wr_en  input  1  write request
wr_data  input  WIDTH  write data
rd_en  input  1  read request
rd_data  output  WIDTH  read data, registered
rd_valid  output  1  one-cycle strobe: rd_data holds a popped word
count  output  ADDR_W+1  occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_TH
almost_empty  output  1  count <= AE_TH
overflow  output  1  sticky: write rejected because buffer full
underflow  output  1  sticky: read rejected because buffer empty
clr_err  input  1  clears overflow/underflow next edge

Behaviour:
- Reset (rst=1 at edge): count=0, mode_o=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, all pointers=0. Storage array is not cleared. Reset overrides all other inputs that cycle.
- Flags are combinational from count and mode_o; no extra latency. After reset: empty=1, full=0, almost_empty=1 (with AE_TH >= 0), almost_full=(AF_TH==0).
- Read latency is 1 cycle. An accepted read at edge N loads rd_data and sets rd_valid=1 after edge N. rd_valid=0 on every other cycle; rd_data holds its last value.
- Acceptance, with the state sampled before the edge:
  - A write is accepted if !full, or if full with rd_en=1 and a read is also accepted.
  - A read is accepted if !empty.
  - A rejected write sets overflow. A rejected read sets underflow.
  - Rejected operations change no other state.
- FIFO mode:
  - Write goes to mem[wptr], wptr++.
  - Read returns mem[rptr], rptr++.
  - Pointers wrap modulo DEPTH.
  - Simultaneous accepted read and write leave count unchanged.
- LIFO mode:
  - Top index is count-1.
  - Write goes to mem[count], count++.
  - Read returns mem[count-1], count--.
  - Simultaneous accepted read and write: rd_data = old top; wr_data overwrites slot count-1; count unchanged. This applies when full as well.
- Both empty with rd_en and wr_en (either mode): write accepted, read rejected, underflow=1, rd_valid=0. No bypass.
- Mode change:
  - mode_i is loaded into mode_o only on an edge where count==0 and no write is accepted.
  - Otherwise mode_i is ignored.
  - FIFO pointers reset to 0 on a mode load.
- Error flags:
  - clr_err=1 clears overflow/underflow at the edge.
  - If a new error occurs in the same cycle as clr_err, set wins.
- Count arithmetic is ADDR_W+1 bits and never wraps; pointers are ADDR_W bits and wrap naturally.
- rst asserted mid-burst: occupancy is discarded, and a read strobe in flight is suppressed (rd_valid=0 after the reset edge).

Decomposition:
- Shared package lifo_fifo_pkg holds:
  - mode constants MODE_LIFO=0 and MODE_FIFO=1;
  - a helper function for threshold compares, sized to ADDR_W+1.
- One sub-module, buf_ram: DEPTH x WIDTH array with one write port and one synchronous read port (registered output, no reset on the array).
- Top level holds pointers, count, mode register, error flags and acceptance logic.

Test Plan:
- LIFO, push 0x11,0x22,0x33, then pop x3 -> rd_data 0x33,0x22,0x11 on successive cycles, each with rd_valid=1 one cycle after rd_en; count 3->0; empty=1 at end.
- FIFO mode set while empty; push 0x01..0x10 (16 words) -> full=1, count=16; 17th push -> overflow=1, count stays 16; pop x16 -> 0x01..0x10 in order, pointers wrap, empty=1.
- LIFO holding 0xA0,0xB0; rd_en+wr_en with 0xC0 -> rd_data=0xB0, count stays 2; next pop -> 0xC0.
- Empty, rd_en+wr_en with 0x5A -> underflow=1, rd_valid=0, count=1; then clr_err -> underflow=0; then pop -> 0x5A.
- mode_i toggled to 1 while count=3 -> mode_o stays 0; drain to empty, then mode_i=1 -> mode_o=1 after the next edge.
- With count=15, assert rst together with rd_en -> next cycle count=0, empty=1, rd_valid=0, rd_data=0, flags cleared; almost_full/almost_empty track AF_TH=14 / AE_TH=2 crossings during refill.
